fir_upsampler: RTL and testbench

Parametrised 2x horizontal chroma upsampler. Successor to the fixed U/V interpolator: any channel count and sample width, valid/ready handshakes on both sides, automatic edge replication at both line ends, and output clamping. Sits between the SRAM chroma fetch path and the colour-space converter. Each accepted even sample produces one {even, odd} output pair per channel.

---
 rtl/fir_upsampler_pkg.sv | 21 ++
 rtl/fir_tap_mac.sv | 77 +++++++
 rtl/fir_upsampler.sv | 144 ++++++++++++++
 tb/tb_fir_upsampler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_upsampler_pkg.sv
// Shared types and default coefficients for the 2x chroma upsampler.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam int DEF_C0    = 21;
  localparam int DEF_C1    = 52;
  localparam int DEF_C2    = 159;
  localparam int DEF_ROUND = 128;
  localparam int DEF_SHIFT = 8;

  // Signed accumulator width; leaves headroom for the full positive tap sum.
  function automatic int acc_width(input int data_w);
    return data_w + 12;
  endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// One channel: 6-entry sample window, symmetric 6-tap MAC, clamp and output register.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int C0     = DEF_C0,
  parameter int C1     = DEF_C1,
  parameter int C2     = DEF_C2,
  parameter int ROUND  = DEF_ROUND,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              clear,
  input  logic              push,
  input  logic              sol_push,
  input  logic              flush_push,
  input  logic              load,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] even,
  output logic [DATA_W-1:0] odd
);

  localparam int ACC_W = acc_width(DATA_W);
  localparam logic signed [ACC_W-1:0] K0   = ACC_W'(C0);
  localparam logic signed [ACC_W-1:0] K1   = ACC_W'(C1);
  localparam logic signed [ACC_W-1:0] K2   = ACC_W'(C2);
  localparam logic signed [ACC_W-1:0] KR   = ACC_W'(ROUND);
  localparam logic signed [ACC_W-1:0] KMAX = ACC_W'((1 << DATA_W) - 1);

  logic [DATA_W-1:0] win  [6];
  logic [DATA_W-1:0] nwin [6];

  logic signed [ACC_W-1:0] s05, s14, s23, acc, res;
  logic [DATA_W-1:0] odd_next;

  // SOL seeds the right half with x0 so the left edge is replicated by later shifts.
  always_comb begin
    for (int unsigned i = 0; i < 5; i++) nwin[i] = win[i+1];
    nwin[5] = flush_push ? win[5] : x;
    if (sol_push) begin
      nwin[3] = x;
      nwin[4] = x;
      nwin[5] = x;
    end
  end

  always_comb begin
    s05 = ACC_W'(nwin[0]) + ACC_W'(nwin[5]);
    s14 = ACC_W'(nwin[1]) + ACC_W'(nwin[4]);
    s23 = ACC_W'(nwin[2]) + ACC_W'(nwin[3]);
    acc = K0 * s05 - K1 * s14 + K2 * s23 + KR;
    res = acc >>> SHIFT;
    if (res < 0)         odd_next = '0;
    else if (res > KMAX) odd_next = '1;
    else                 odd_next = res[DATA_W-1:0];
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 6; i++) win[i] <= '0;
      even <= '0;
      odd  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < 6; i++) win[i] <= '0;
    end else begin
      if (push) begin
        for (int unsigned i = 0; i < 6; i++) win[i] <= nwin[i];
      end
      if (load) begin
        even <= nwin[2];
        odd  <= odd_next;
      end
    end
  end

endmodule

// File: rtl/fir_upsampler.sv
// 2x horizontal chroma upsampler: shared line FSM and handshakes over NUM_CH tap/MAC channels.
module fir_upsampler
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter int C0     = DEF_C0,
  parameter int C1     = DEF_C1,
  parameter int C2     = DEF_C2,
  parameter int ROUND  = DEF_ROUND,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                     CLOCK_50_I,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_sol,
  input  logic                     in_eol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_even,
  output logic [NUM_CH*DATA_W-1:0] out_odd,
  output logic                     out_sol,
  output logic                     out_eol,
  output logic                     line_err
);

  state_t     state, state_next;
  logic [1:0] push_cnt, push_cnt_next;
  logic [1:0] flush_cnt, flush_cnt_next;
  logic       slot_free, accept;
  logic       push, sol_push, flush_push, set_err;
  logic       emit, emit_sol, emit_eol;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state != S_FLUSH) && slot_free && !clear;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    push           = 1'b0;
    sol_push       = 1'b0;
    flush_push     = 1'b0;
    set_err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_sol) begin
            push       = 1'b1;
            sol_push   = 1'b1;
            state_next = in_eol ? S_FLUSH : S_RUN;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          push = 1'b1;
          if (in_sol) begin
            sol_push = 1'b1;
            set_err  = 1'b1;
          end
          if (in_eol) state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (slot_free && !clear) begin
          push       = 1'b1;
          flush_push = 1'b1;
          if (flush_cnt == 2'd2) begin
            flush_cnt_next = '0;
            state_next     = S_IDLE;
          end else begin
            flush_cnt_next = flush_cnt + 2'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    push_cnt_next = sol_push ? 2'd0 : ((push_cnt == 2'd3) ? 2'd3 : push_cnt + 2'd1);
    emit          = push && (push_cnt_next == 2'd3);
    emit_sol      = push && !sol_push && (push_cnt == 2'd2);
    emit_eol      = flush_push && (flush_cnt == 2'd2);
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      push_cnt  <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      line_err  <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      push_cnt  <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (push) push_cnt <= push_cnt_next;
      if (emit) begin
        out_valid <= 1'b1;
        out_sol   <= emit_sol;
        out_eol   <= emit_eol;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (set_err) line_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fir_tap_mac #(
      .DATA_W (DATA_W),
      .C0     (C0),
      .C1     (C1),
      .C2     (C2),
      .ROUND  (ROUND),
      .SHIFT  (SHIFT)
    ) u_mac (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .clear      (clear),
      .push       (push),
      .sol_push   (sol_push),
      .flush_push (flush_push),
      .load       (emit),
      .x          (in_data[g*DATA_W +: DATA_W]),
      .even       (out_even[g*DATA_W +: DATA_W]),
      .odd        (out_odd[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_fir_upsampler.sv
// Randomized line-level bench for fir_upsampler against a clamped-index interpolation model.
module tb_fir_upsampler;

  localparam int DW  = 8;
  localparam int NCH = 2;
  localparam int W   = DW * NCH;

  logic         CLOCK_50_I = 1'b0;
  logic         resetn, clear, in_valid, in_ready, in_sol, in_eol;
  logic [W-1:0] in_data, out_even, out_odd;
  logic         out_valid, out_ready, out_sol, out_eol, line_err;

  fir_upsampler #(.DATA_W(DW), .NUM_CH(NCH)) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sol     (in_sol),
    .in_eol     (in_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_even   (out_even),
    .out_odd    (out_odd),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .line_err   (line_err)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  typedef struct packed {
    logic [W-1:0] even;
    logic [W-1:0] odd;
    logic         sol;
    logic         eol;
  } pair_t;

  pair_t        exp_q[$];
  logic [W-1:0] line_q[$];
  logic [W-1:0] tx_q[$];
  bit           in_line, err_m, mon_en, rand_ready;
  int           total, bad, stall_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int samp(input int idx, input int ch);
    logic [W-1:0] v;
    int n = line_q.size();
    if (idx < 0) idx = 0;
    if (idx > n - 1) idx = n - 1;
    v = line_q[idx];
    return int'(v[ch*DW +: DW]);
  endfunction

  // Pair k interpolates between U[k] and U[k+1] using U[k-2..k+3], indices clamped to the line.
  function automatic pair_t ref_pair(input int k, input bit last);
    pair_t p;
    int    a;
    p.even = '0;
    p.odd  = '0;
    p.sol  = (k == 0);
    p.eol  = last;
    for (int ch = 0; ch < NCH; ch++) begin
      a = 21 * (samp(k-2, ch) + samp(k+3, ch)) - 52 * (samp(k-1, ch) + samp(k+2, ch))
        + 159 * (samp(k, ch) + samp(k+1, ch)) + 128;
      a = a >>> 8;
      if (a < 0) a = 0;
      if (a > 255) a = 255;
      p.even[ch*DW +: DW] = DW'(samp(k, ch));
      p.odd[ch*DW +: DW]  = DW'(a);
    end
    return p;
  endfunction

  task automatic model_accept(input logic [W-1:0] d, input bit s, input bit e);
    int n;
    if (!in_line && !s) begin
      err_m = 1;
      return;
    end
    if (s) begin
      if (in_line) err_m = 1;
      line_q.delete();
      in_line = 1;
    end
    line_q.push_back(d);
    n = line_q.size();
    if (e) begin
      for (int k = (n > 4 ? n - 4 : 0); k < n; k++) exp_q.push_back(ref_pair(k, k == n - 1));
      in_line = 0;
    end else if (n >= 4) begin
      exp_q.push_back(ref_pair(n - 4, 1'b0));
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit s, input bit e, input int gapmax);
    bit ok = 0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge CLOCK_50_I); #1;
    end
    in_valid = 1; in_data = d; in_sol = s; in_eol = e;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLOCK_50_I);
      ok = in_ready;
      @(posedge CLOCK_50_I); #1;
    end
    in_valid = 0; in_sol = 0; in_eol = 0;
    if (!ok) check("accept_timeout", 0, 1);
    else model_accept(d, s, e);
  endtask

  task automatic send_line(input int gapmax, input int stall_at);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == stall_at) stall_cnt = 5;
      send(tx_q[i], i == 0, i == tx_q.size() - 1, gapmax);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(posedge CLOCK_50_I); #1;
    end
    repeat (3) begin
      @(posedge CLOCK_50_I); #1;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  // Output sink: scoreboard pop on handshake, plus stability of stalled outputs.
  initial begin : monitor
    bit          held = 0;
    logic [34:0] hold_v;
    pair_t       e;
    forever begin
      @(negedge CLOCK_50_I);
      if (!mon_en) begin
        held = 0;
      end else begin
        if (held) check("hold_stable", {out_valid, out_sol, out_eol, out_even, out_odd}, hold_v);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_pair", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("even", out_even, e.even);
            check("odd", out_odd, e.odd);
            check("sol", out_sol, e.sol);
            check("eol", out_eol, e.eol);
          end
        end
        if (out_valid && !out_ready) begin
          held   = 1;
          hold_v = {out_valid, out_sol, out_eol, out_even, out_odd};
          check("in_ready_stall", in_ready, 0);
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge CLOCK_50_I); #1;
      if (stall_cnt > 0) begin
        out_ready = 0;
        stall_cnt--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    resetn = 0; clear = 0; in_valid = 0; in_sol = 0; in_eol = 0; in_data = '0;
    out_ready = 1; rand_ready = 0; mon_en = 0; stall_cnt = 0;
    total = 0; bad = 0; in_line = 0; err_m = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_even", out_even, 0);
    check("rst_out_odd", out_odd, 0);
    check("rst_out_sol", out_sol, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_line_err", line_err, 0);
    repeat (2) @(posedge CLOCK_50_I);
    #1 resetn = 1;
    @(negedge CLOCK_50_I);
    check("in_ready_after_reset", in_ready, 1);
    mon_en = 1;
    @(posedge CLOCK_50_I); #1;

    tx_q.delete();
    for (int i = 0; i < 8; i++) tx_q.push_back({8'd100, 8'd100});
    send_line(0, -1);
    drain();

    tx_q = '{16'h00FF, 16'h00FF, 16'h00FF, 16'hFF00, 16'hFF00, 16'hFF00};
    send_line(0, -1);
    drain();

    tx_q = '{16'hFF00, 16'h00FF, 16'hFF00, 16'hFF00, 16'h00FF, 16'hFF00};
    send_line(1, -1);
    drain();

    send({8'd7, 8'd7}, 1, 1, 0);
    drain();

    tx_q = '{{8'd10, 8'd200}, {8'd50, 8'd30}};
    send_line(0, -1);
    drain();

    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(W'($urandom));
    send_line(0, 6);
    stall_cnt = 5;
    drain();

    send({8'd1, 8'd2}, 0, 0, 0);
    repeat (3) begin
      @(posedge CLOCK_50_I); #1;
    end
    check("line_err_idle", line_err, err_m);
    drain();

    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(W'($urandom));
    for (int i = 0; i < 6; i++) send(tx_q[i], i == 0, 0, 0);
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(W'($urandom));
    send_line(0, -1);
    drain();

    rand_ready = 1;
    for (int l = 0; l < 40; l++) begin
      n = $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) send(W'($urandom), 0, $urandom_range(0, 1), 2);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(W'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < n; i++) send(tx_q[i], i == 0, 0, 2);
      end else begin
        send_line(2, -1);
      end
    end
    rand_ready = 0;
    if (in_line) begin
      tx_q = '{16'h1234};
      send_line(0, -1);
    end
    drain();
    check("line_err_random", line_err, err_m);

    clear = 1;
    @(negedge CLOCK_50_I);
    check("clear_in_ready", in_ready, 0);
    @(posedge CLOCK_50_I); #1 clear = 0;
    @(negedge CLOCK_50_I);
    check("clear_keeps_err", line_err, err_m);
    check("clear_in_ready_back", in_ready, 1);
    @(posedge CLOCK_50_I); #1;

    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(W'($urandom));
    send_line(0, -1);
    @(negedge CLOCK_50_I);
    mon_en = 0;
    #1 resetn = 0;
    #1;
    check("midflush_out_valid", out_valid, 0);
    check("midflush_out_even", out_even, 0);
    check("midflush_out_odd", out_odd, 0);
    check("midflush_out_sol", out_sol, 0);
    check("midflush_out_eol", out_eol, 0);
    check("midflush_line_err", line_err, 0);
    exp_q.delete();
    in_line = 0;
    err_m = 0;
    @(posedge CLOCK_50_I); #1 resetn = 1;
    @(negedge CLOCK_50_I);
    check("in_ready_after_rst2", in_ready, 1);
    mon_en = 1;
    @(posedge CLOCK_50_I); #1;

    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(W'($urandom));
    send_line(1, -1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
